// File: rtl/jump_pkg.sv
// Shared definitions for the jump controller: FSM state encoding and default
// tuning constants used by the sprite vertical-motion logic.
package jump_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    RISE   = 2'd2,
    FALL   = 2'd3
  } jump_state_e;

  localparam int GROUND_Y_DEF = 400;
  localparam int V_MAX_DEF    = 31;
  localparam int GRAVITY_DEF  = 1;

endpackage

// File: rtl/jump_tick_edge.sv
// Rising-edge detector turning a slow divided rate signal into a one-cycle tick
// in the fast clock domain; usable by any slow-rate game block.
module jump_tick_edge
  import jump_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rate_i,
  output logic tick_o
);

  logic rate_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rate_q <= 1'b0;
    end else begin
      rate_q <= rate_i;
    end
  end

  assign tick_o = rate_i & ~rate_q;

endmodule

// File: rtl/jump_physics.sv
// Vertical motion for the player sprite: charge while held, launch on release,
// gravity per tick, landing pulse. Optional build macro: JUMP_AUTO_RELEASE_EN.
module jump_physics
  import jump_pkg::*;
#(
  parameter int Y_W         = 10,
  parameter int V_W         = 6,
  parameter int GROUND_Y    = GROUND_Y_DEF,
  parameter int V_MAX       = V_MAX_DEF,
  parameter int GRAVITY     = GRAVITY_DEF,
  parameter int CHARGE_STEP = 1
) (
  input  logic           clk_vga,
  input  logic           rst_n,
  input  logic           clk_jump,
  input  logic           btn_jump,
  output logic [Y_W-1:0] player_y,
  output logic [V_W-1:0] charge,
  output logic           airborne,
  output logic           land_pulse,
  output logic [1:0]     state
);

  localparam logic [V_W:0]   VMAX_X  = V_MAX[V_W:0];
  localparam logic [V_W-1:0] VMAX_V  = V_MAX[V_W-1:0];
  localparam logic [V_W:0]   GRAV_X  = GRAVITY[V_W:0];
  localparam logic [V_W-1:0] GRAV_V  = GRAVITY[V_W-1:0];
  localparam logic [V_W:0]   CSTEP_X = CHARGE_STEP[V_W:0];
  localparam logic [Y_W:0]   GND_X   = GROUND_Y[Y_W:0];
  localparam logic [Y_W-1:0] GND_Y   = GROUND_Y[Y_W-1:0];

  logic tick;

  jump_tick_edge u_tick (
    .clk_i  (clk_vga),
    .rst_ni (rst_n),
    .rate_i (clk_jump),
    .tick_o (tick)
  );

  jump_state_e    state_q;
  logic [Y_W-1:0] player_y_q;
  logic [V_W-1:0] charge_q;
  logic [V_W-1:0] vel_q;
  logic           airborne_q;
  logic           land_pulse_q;

  logic [V_W:0]   charge_inc;
  logic [V_W-1:0] charge_sat;
  logic [Y_W-1:0] vel_y;
  logic [Y_W-1:0] rise_y;
  logic [V_W-1:0] rise_vel;
  logic [V_W:0]   fall_inc;
  logic [V_W-1:0] fall_vel;
  logic [Y_W-1:0] fall_vel_y;
  logic [Y_W:0]   fall_sum;
  logic           fall_land;

  // Saturating next-tick arithmetic; the FSM picks whichever result applies.
  always_comb begin
    charge_inc = {1'b0, charge_q} + CSTEP_X;
    charge_sat = (charge_inc > VMAX_X) ? VMAX_V : charge_inc[V_W-1:0];

    vel_y            = '0;
    vel_y[V_W-1:0]   = vel_q;
    rise_y           = (player_y_q < vel_y) ? '0 : player_y_q - vel_y;
    rise_vel         = (vel_q < GRAV_V) ? '0 : vel_q - GRAV_V;

    fall_inc              = {1'b0, vel_q} + GRAV_X;
    fall_vel              = (fall_inc > VMAX_X) ? VMAX_V : fall_inc[V_W-1:0];
    fall_vel_y            = '0;
    fall_vel_y[V_W-1:0]   = fall_vel;
    fall_sum              = {1'b0, player_y_q} + {1'b0, fall_vel_y};
    fall_land             = (fall_sum >= GND_X);
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      player_y_q   <= GND_Y;
      charge_q     <= '0;
      vel_q        <= '0;
      airborne_q   <= 1'b0;
      land_pulse_q <= 1'b0;
    end else begin
      land_pulse_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            if (btn_jump) begin
              state_q  <= CHARGE;
              charge_q <= '0;
            end
          end
          CHARGE: begin
`ifdef JUMP_AUTO_RELEASE_EN
            if (btn_jump && (charge_q == VMAX_V)) begin
              vel_q      <= VMAX_V;
              state_q    <= RISE;
              airborne_q <= 1'b1;
            end else
`endif
            if (btn_jump) begin
              charge_q <= charge_sat;
            end else if (charge_q == '0) begin
              state_q <= IDLE;
            end else begin
              vel_q      <= charge_q;
              state_q    <= RISE;
              airborne_q <= 1'b1;
            end
          end
          RISE: begin
            // Apex tick: switch to falling without moving the sprite.
            if (vel_q == '0) begin
              state_q <= FALL;
            end else begin
              player_y_q <= rise_y;
              vel_q      <= rise_vel;
            end
          end
          FALL: begin
            if (fall_land) begin
              player_y_q   <= GND_Y;
              vel_q        <= '0;
              charge_q     <= '0;
              land_pulse_q <= 1'b1;
              airborne_q   <= 1'b0;
              state_q      <= IDLE;
            end else begin
              player_y_q <= fall_sum[Y_W-1:0];
              vel_q      <= fall_vel;
            end
          end
        endcase
      end
    end
  end

  assign player_y   = player_y_q;
  assign charge     = charge_q;
  assign airborne   = airborne_q;
  assign land_pulse = land_pulse_q;
  assign state      = state_q;

endmodule

// File: tb/tb_jump_physics.sv
// Scoreboard bench for jump_physics: a driver issues rate ticks and pushes
// model expectations; a monitor pops and compares on every observed tick.
module tb_jump_physics;

  logic       clk_vga = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clk_jump = 1'b0;
  logic       btn_jump = 1'b0;
  logic [9:0] player_y;
  logic [5:0] charge;
  logic       airborne;
  logic       land_pulse;
  logic [1:0] state;

  jump_physics dut (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .clk_jump   (clk_jump),
    .btn_jump   (btn_jump),
    .player_y   (player_y),
    .charge     (charge),
    .airborne   (airborne),
    .land_pulse (land_pulse),
    .state      (state)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    int y;
    int ch;
    int st;
    bit air;
    bit land;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   tick_no = 0;

`ifdef JUMP_AUTO_RELEASE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Reference model: plain integer arithmetic following the jump rules.
  int m_y = 400, m_ch = 0, m_vel = 0, m_st = 0;

  function automatic exp_t reset_exp();
    exp_t e;
    e.y = 400; e.ch = 0; e.st = 0; e.air = 0; e.land = 0;
    return e;
  endfunction

  function automatic exp_t model_step(input bit b);
    exp_t e;
    bit land = 0;
    if (m_st == 0) begin
      if (b) begin m_st = 1; m_ch = 0; end
    end else if (m_st == 1) begin
      if (AUTO && b && m_ch == 31) begin m_vel = 31; m_st = 2; end
      else if (b) m_ch = (m_ch + 1 > 31) ? 31 : m_ch + 1;
      else if (m_ch == 0) m_st = 0;
      else begin m_vel = m_ch; m_st = 2; end
    end else if (m_st == 2) begin
      if (m_vel == 0) m_st = 3;
      else begin
        m_y   = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
        m_vel = (m_vel - 1 < 0) ? 0 : m_vel - 1;
      end
    end else begin
      m_vel = (m_vel + 1 > 31) ? 31 : m_vel + 1;
      if (m_y + m_vel >= 400) begin
        m_y = 400; m_vel = 0; m_ch = 0; m_st = 0; land = 1;
      end else m_y = m_y + m_vel;
    end
    e.y = m_y; e.ch = m_ch; e.st = m_st; e.air = (m_st >= 2); e.land = land;
    return e;
  endfunction

  task automatic compare(input string nm, input exp_t e);
    logic [19:0] act, req;
    act = {player_y, charge, state, airborne, land_pulse};
    req = {10'(e.y), 6'(e.ch), 2'(e.st), e.air, e.land};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t: got y=%0d ch=%0d st=%0d air=%0b land=%0b, want y=%0d ch=%0d st=%0d air=%0b land=%0b",
               nm, $time, player_y, charge, state, airborne, land_pulse,
               e.y, e.ch, e.st, e.air, e.land);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Monitor: detects each rate tick the same way the DUT sees it and compares.
  initial begin
    bit   cj_last = 1'b0;
    bit   tk;
    exp_t cur;
    cur = reset_exp();
    forever begin
      @(posedge clk_vga);
      tk = rst_n && clk_jump && !cj_last;
      cj_last = rst_n ? clk_jump : 1'b0;
      #1;
      if (!rst_n) begin
        cur = reset_exp();
        compare("reset", cur);
      end else if (tk) begin
        tick_no++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_empty: tick %0d had no expectation", tick_no);
        end else begin
          cur = sb.pop_front();
          compare("tick", cur);
          $display("tick %0d btn=%0b y=%0d ch=%0d st=%0d air=%0b land=%0b",
                   tick_no, btn_jump, player_y, charge, state, airborne, land_pulse);
          cur.land = 1'b0;
        end
      end else begin
        compare("hold", cur);
      end
    end
  end

  task automatic do_tick(input bit b, output int y_after);
    @(negedge clk_vga);
    btn_jump = b;
    clk_jump = 1'b1;
    sb.push_back(model_step(b));
    @(negedge clk_vga);
    y_after = int'(player_y);
    @(negedge clk_vga);
    clk_jump = 1'b0;
    @(negedge clk_vga);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_vga);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_vga);
      clk_jump = 1'($urandom_range(0, 1));
      btn_jump = 1'($urandom_range(0, 1));
    end
    clk_jump = 1'b0;
    btn_jump = 1'b0;
    m_y = 400; m_ch = 0; m_vel = 0; m_st = 0;
    @(negedge clk_vga);
    rst_n = 1'b1;
  endtask

  initial begin
    int y;
    int lit[7] = '{397, 395, 394, 394, 395, 397, 400};
    int n;

    do_reset(12);
    repeat (3) do_tick(1'b0, y);

    // Three-tick charge then release: known trajectory.
    do_tick(1'b1, y);
    repeat (3) do_tick(1'b1, y);
    chk_int("charge3", int'(charge), 3);
    do_tick(1'b0, y);
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0, y);
      chk_int($sformatf("traj%0d", i), y, lit[i]);
    end
    chk_int("idle_after_land", int'(state), 0);

    // Press then release before any charge accumulates.
    do_tick(1'b1, y);
    do_tick(1'b0, y);
    chk_int("short_press_y", y, 400);
    chk_int("short_press_state", int'(state), 0);

    // Long hold: saturation, clamp at top, then fall and land.
    do_tick(1'b1, y);
    repeat (40) do_tick(1'b1, y);
    n = 0;
    while (state != 2'd0 && n < 200) begin
      do_tick(1'($urandom_range(0, 1)), y);
      n++;
    end
    chk_int("long_jump_landed", int'(state), 0);
    chk_int("long_jump_y", int'(player_y), 400);

    // Reset mid-rise, then normal operation resumes.
    do_tick(1'b1, y);
    repeat (6) do_tick(1'b1, y);
    do_tick(1'b0, y);
    repeat (2) do_tick(1'b0, y);
    do_reset(3);
    chk_int("reset_mid_rise_state", int'(state), 0);
    repeat (2) do_tick(1'b0, y);

    // Randomized hold/release episodes with in-air button noise.
    repeat (20) begin
      n = $urandom_range(0, 35);
      repeat (n) do_tick(1'b1, y);
      n = $urandom_range(1, 60);
      repeat (n) do_tick(($urandom_range(0, 3) == 0), y);
    end

    repeat (4) @(negedge clk_vga);
    chk_int("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
